// File: rtl/spi_slave_rx.sv
// SPI slave receiver (CPOL=0, CPHA=0): oversamples sclk/mosi/ss on clk, deserialises
// DATA_W-bit frames onto a valid/ready port and shifts tx_data back out on miso.
module spi_slave_rx #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LSB_FIRST   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    input  logic [DATA_W-1:0] tx_data,
    output logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overrun,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
    logic                   sclk_d, ss_d;
    logic                   sclk_s, mosi_s, ss_s;
    logic                   sclk_rise, sclk_fall, ss_rise;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      rx_sr, tx_sr;

    // ss chain resets high so a select still asserted across reset is not taken as a new frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            ss_d      <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign ss_s      = ss_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign ss_rise   = ss_s & ~ss_d;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_rise) state_nxt = SHIFT;
            SHIFT: begin
                if (!ss_s)
                    state_nxt = IDLE;
                else if (sclk_rise && bit_cnt == CNT_W'(DATA_W - 1))
                    state_nxt = DONE;
            end
            DONE:    state_nxt = ss_s ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sr     <= '0;
            tx_sr     <= '0;
            bit_cnt   <= '0;
            miso      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
            if (rx_valid && rx_ready) rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    if (ss_rise) begin
                        tx_sr   <= tx_data;
                        miso    <= (LSB_FIRST != 0) ? tx_data[0] : tx_data[DATA_W-1];
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    if (!ss_s) begin
                        frame_err <= (bit_cnt != '0);
                        bit_cnt   <= '0;
                        miso      <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            if (LSB_FIRST != 0) rx_sr <= {mosi_s, rx_sr[DATA_W-1:1]};
                            else                rx_sr <= {rx_sr[DATA_W-2:0], mosi_s};
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                        // the falling edge that trails the previous frame's last bit must
                        // not skip past bit 0 of a recaptured back-to-back frame
                        if (sclk_fall && bit_cnt != '0) begin
                            if (LSB_FIRST != 0) begin
                                tx_sr <= tx_sr >> 1;
                                miso  <= tx_sr[1];
                            end else begin
                                tx_sr <= tx_sr << 1;
                                miso  <= tx_sr[DATA_W-2];
                            end
                        end
                    end
                end
                DONE: begin
                    rx_data  <= rx_sr;
                    rx_valid <= 1'b1;
                    overrun  <= rx_valid & ~rx_ready;
                    bit_cnt  <= '0;
                    if (ss_s) begin
                        tx_sr <= tx_data;
                        miso  <= (LSB_FIRST != 0) ? tx_data[0] : tx_data[DATA_W-1];
                    end else begin
                        miso <= 1'b0;
                    end
                end
                default: miso <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomised bench for spi_slave_rx: an SPI master drives two instances (LSB-first/2-stage
// and MSB-first/3-stage); a scoreboard checks delivered bytes, overrun and frame errors.
module tb_spi_slave_rx;

    typedef struct packed {
        logic [7:0] data;
        logic       dropped;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst, sclk, mosi, ss, rx_ready;
    logic [7:0] tx_data;
    logic       miso0, v0, ov0, fe0, busy0;
    logic       miso1, v1, ov1, fe1, busy1;
    logic [7:0] d0, d1;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0, errors = 0;
    int   ov_cnt0 = 0, ov_cnt1 = 0, fe_cnt0 = 0, fe_cnt1 = 0;
    int   lat0, lat1;

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .LSB_FIRST(1)) dut0 (
        .clk(clk), .reset(rst), .sclk(sclk), .mosi(mosi), .ss(ss), .tx_data(tx_data),
        .miso(miso0), .rx_data(d0), .rx_valid(v0), .rx_ready(rx_ready),
        .overrun(ov0), .frame_err(fe0), .busy(busy0));

    spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(3), .LSB_FIRST(0)) dut1 (
        .clk(clk), .reset(rst), .sclk(sclk), .mosi(mosi), .ss(ss), .tx_data(tx_data),
        .miso(miso1), .rx_data(d1), .rx_valid(v1), .rx_ready(rx_ready),
        .overrun(ov1), .frame_err(fe1), .busy(busy1));

    function automatic logic [7:0] bitrev(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // stream[i] is the i-th bit on the wire; an LSB-first slave sees stream, MSB-first its reverse
    task automatic push_exp(input logic [7:0] stream, input logic dropped);
        q0.push_back('{data: stream, dropped: dropped});
        q1.push_back('{data: bitrev(stream), dropped: dropped});
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] stream, input int nbits, input int p,
                             input bit measure, output logic [7:0] m0, output logic [7:0] m1);
        m0 = '0;
        m1 = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = stream[i];
            wait_clk(p);
            sclk = 1'b1;
            m0[i]   = miso0;
            m1[7-i] = miso1;
            if (measure && i == nbits - 1) begin
                lat0 = -1;
                lat1 = -1;
                for (int c = 1; c <= p; c++) begin
                    @(posedge clk);
                    #1;
                    if (v0 && lat0 < 0) lat0 = c;
                    if (v1 && lat1 < 0) lat1 = c;
                end
                @(negedge clk);
            end else begin
                wait_clk(p);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic full_frame(input logic [7:0] stream, input logic [7:0] tx, input int p,
                              input string name);
        logic [7:0] m0, m1;
        tx_data = tx;
        ss = 1'b1;
        wait_clk(p);
        push_exp(stream, 1'b0);
        send_bits(stream, 8, p, 1'b0, m0, m1);
        wait_clk(p);
        ss = 1'b0;
        wait_clk(10);
        chk({name, " miso0"}, {24'h0, m0}, {24'h0, tx});
        chk({name, " miso1"}, {24'h0, m1}, {24'h0, tx});
    endtask

    // monitor: overrun consumes the stale entry, acceptance consumes the delivered one
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (fe0) fe_cnt0++;
            if (fe1) fe_cnt1++;
            if (ov0) begin
                ov_cnt0++;
                checks++;
                if (q0.size() == 0) begin
                    errors++; $display("FAIL overrun0: unexpected overrun, queue empty");
                end else begin
                    e = q0.pop_front();
                    if (!e.dropped) begin
                        errors++; $display("FAIL overrun0: got overrun expected none on %0h", e.data);
                    end
                end
            end
            if (ov1) begin
                ov_cnt1++;
                checks++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL overrun1: unexpected overrun, queue empty");
                end else begin
                    e = q1.pop_front();
                    if (!e.dropped) begin
                        errors++; $display("FAIL overrun1: got overrun expected none on %0h", e.data);
                    end
                end
            end
            if (v0 && rx_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++; $display("FAIL rx0: got %0h expected no byte", d0);
                end else begin
                    e = q0.pop_front();
                    if (e.dropped || d0 !== e.data) begin
                        errors++; $display("FAIL rx0: got %0h expected %0h (dropped=%0b)", d0, e.data, e.dropped);
                    end
                end
            end
            if (v1 && rx_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    errors++; $display("FAIL rx1: got %0h expected no byte", d1);
                end else begin
                    e = q1.pop_front();
                    if (e.dropped || d1 !== e.data) begin
                        errors++; $display("FAIL rx1: got %0h expected %0h (dropped=%0b)", d1, e.data, e.dropped);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] m0, m1, m2, m3;
        int fe_prev0, fe_prev1;
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; ss = 1'b0; rx_ready = 1'b1; tx_data = 8'h00;
        wait_clk(3);
        chk("reset busy0", {31'h0, busy0}, 32'h0);
        chk("reset busy1", {31'h0, busy1}, 32'h0);
        chk("reset outputs0", {19'h0, d0, v0, ov0, fe0, miso0, busy0}, 32'h0);
        chk("reset outputs1", {19'h0, d1, v1, ov1, fe1, miso1, busy1}, 32'h0);
        rst = 1'b0;
        wait_clk(3);
        chk("idle miso0", {31'h0, miso0}, 32'h0);

        // basic byte with latency measurement
        tx_data = 8'h96;
        ss = 1'b1;
        wait_clk(6);
        chk("busy after ss0", {31'h0, busy0}, 32'h1);
        push_exp(8'hA5, 1'b0);
        send_bits(8'hA5, 8, 6, 1'b1, m0, m1);
        wait_clk(6);
        ss = 1'b0;
        wait_clk(10);
        chk("latency0", lat0, 32'd4);
        chk("latency1", lat1, 32'd5);
        chk("basic miso0", {24'h0, m0}, 32'h96);
        chk("basic miso1", {24'h0, m1}, 32'h96);
        chk("basic no overrun", ov_cnt0 + ov_cnt1, 32'd0);
        chk("basic no frame_err", fe_cnt0 + fe_cnt1, 32'd0);

        // back-to-back frames with the consumer stalled
        rx_ready = 1'b0;
        tx_data = 8'h6C;
        ss = 1'b1;
        wait_clk(6);
        push_exp(8'h3C, 1'b1);
        send_bits(8'h3C, 8, 6, 1'b0, m0, m1);
        push_exp(8'hC3, 1'b0);
        send_bits(8'hC3, 8, 6, 1'b0, m2, m3);
        wait_clk(6);
        ss = 1'b0;
        wait_clk(10);
        chk("b2b overrun0", ov_cnt0, 32'd1);
        chk("b2b overrun1", ov_cnt1, 32'd1);
        chk("b2b held valid0", {31'h0, v0}, 32'h1);
        chk("b2b held data0", {24'h0, d0}, 32'hC3);
        chk("b2b held data1", {24'h0, d1}, {24'h0, bitrev(8'hC3)});
        chk("b2b miso0 f1", {24'h0, m0}, 32'h6C);
        chk("b2b miso0 f2", {24'h0, m2}, 32'h6C);
        chk("b2b miso1 f2", {24'h0, m3}, 32'h6C);
        rx_ready = 1'b1;
        wait_clk(3);
        chk("b2b released valid0", {31'h0, v0}, 32'h0);

        // abort after five bits
        fe_prev0 = fe_cnt0; fe_prev1 = fe_cnt1;
        ss = 1'b1;
        wait_clk(6);
        send_bits(8'($urandom), 5, 6, 1'b0, m0, m1);
        wait_clk(6);
        ss = 1'b0;
        wait_clk(10);
        chk("abort frame_err0", fe_cnt0 - fe_prev0, 32'd1);
        chk("abort frame_err1", fe_cnt1 - fe_prev1, 32'd1);
        chk("abort valid0", {31'h0, v0}, 32'h0);
        chk("abort idle0", {31'h0, busy0}, 32'h0);
        chk("abort idle1", {31'h0, busy1}, 32'h0);
        full_frame(8'h81, 8'h33, 6, "after abort");

        // miso return while master sends all ones
        full_frame(8'hFF, 8'h5A, 7, "miso return");

        // reset mid-frame
        fe_prev0 = fe_cnt0; fe_prev1 = fe_cnt1;
        ss = 1'b1;
        wait_clk(6);
        send_bits(8'h07, 3, 6, 1'b0, m0, m1);
        rst = 1'b1;
        wait_clk(2);
        chk("reset mid busy0", {31'h0, busy0}, 32'h0);
        chk("reset mid miso1", {31'h0, miso1}, 32'h0);
        rst = 1'b0;
        ss = 1'b0;
        wait_clk(10);
        full_frame(8'h0F, 8'hE1, 6, "after reset");
        chk("reset no frame_err0", fe_cnt0 - fe_prev0, 32'd0);
        chk("reset no frame_err1", fe_cnt1 - fe_prev1, 32'd0);

        // first wire bit only: LSB-first sees 0x01, MSB-first sees 0x80
        full_frame(8'h01, 8'h80, 5, "single bit");

        for (int n = 0; n < 20; n++)
            full_frame(8'($urandom), 8'($urandom), int'($urandom_range(5, 9)), "random");

        chk("final queue0", q0.size(), 32'd0);
        chk("final queue1", q1.size(), 32'd0);
        chk("final overrun0", ov_cnt0, 32'd1);
        chk("final frame_err0", fe_cnt0, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
